// File: rtl/sprite_blitter_if.sv
// Video-side bus of the sprite blitter: raster coordinates, show/hide requests,
// sprite ROM read port and the pixel/valid pair handed to the mixer.
interface sprite_blitter_if #(
  parameter int ADDR_W = 13
) ();
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              frame_start;
  logic              show;
  logic              hide;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              visible;

  modport master (
    output hcount, vcount, frame_start, show, hide, pos_x, pos_y, rom_data,
    input  rom_addr, pix_out, pix_valid, visible
  );

  modport slave (
    input  hcount, vcount, frame_start, show, hide, pos_x, pos_y, rom_data,
    output rom_addr, pix_out, pix_valid, visible
  );
endinterface

// File: rtl/sprite_blitter.sv
// Raster-scan sprite blitter: ROM address generation, transparency keying and
// show/hide sequencing. Optional flashing is built when SPRITE_FLASH_EN is defined.
module sprite_blitter #(
  parameter int         SPR_W        = 94,
  parameter int         SPR_H        = 70,
  parameter int         ADDR_W       = 13,
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480,
  parameter logic [7:0] KEY          = 8'h00,
  parameter int         FLASH_FRAMES = 30
) (
  input logic            clk_pix,
  input logic            rst_n,
  sprite_blitter_if.slave bus
);

  localparam logic [1:0] ST_HIDDEN  = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_VISIBLE = 2'd2;
  localparam logic [1:0] ST_HIDING  = 2'd3;

  localparam logic [9:0]        MAX_X     = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0]        MAX_Y     = 10'(V_ACTIVE - SPR_H);
  localparam logic [10:0]       W11       = 11'(SPR_W);
  localparam logic [10:0]       H11       = 11'(SPR_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPR_W * SPR_H - 1);

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic              latch_s;
  logic              visible_r;
  logic [9:0]        px_r;
  logic [9:0]        py_r;
  logic [9:0]        clamp_x_s;
  logic [9:0]        clamp_y_s;
  logic [ADDR_W-1:0] addr_r;
  logic              on_s;
  logic              win_s;
  logic              win_d1_r;
  logic [7:0]        pix_out_r;
  logic              pix_valid_r;
  logic              blank_s;

  // Next-state decode; latch_s marks the frame_starts that (re)capture the position
  always_comb begin
    next_state_s = state_r;
    latch_s      = 1'b0;
    case (state_r)
      ST_HIDDEN: begin
        if (bus.show && !bus.hide) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = ST_HIDDEN;
        end
      end
      ST_ARMED: begin
        if (bus.hide) begin
          next_state_s = ST_HIDDEN;
        end else if (bus.frame_start) begin
          next_state_s = ST_VISIBLE;
          latch_s      = 1'b1;
        end else begin
          next_state_s = ST_ARMED;
        end
      end
      ST_VISIBLE: begin
        latch_s = bus.frame_start;
        if (bus.hide) begin
          next_state_s = ST_HIDING;
        end else begin
          next_state_s = ST_VISIBLE;
        end
      end
      ST_HIDING: begin
        // A fresh show cancels the pending hide even on a frame boundary
        if (bus.show && !bus.hide) begin
          next_state_s = ST_VISIBLE;
          latch_s      = bus.frame_start;
        end else if (bus.frame_start) begin
          next_state_s = ST_HIDDEN;
        end else begin
          next_state_s = ST_HIDING;
        end
      end
      default: begin
        next_state_s = ST_HIDDEN;
      end
    endcase
  end

  // Clamp the requested position so the sprite never wraps off the raster
  always_comb begin
    clamp_x_s = bus.pos_x;
    clamp_y_s = bus.pos_y;
    if (bus.pos_x > MAX_X) begin
      clamp_x_s = MAX_X;
    end else begin
      clamp_x_s = bus.pos_x;
    end
    if (bus.pos_y > MAX_Y) begin
      clamp_y_s = MAX_Y;
    end else begin
      clamp_y_s = bus.pos_y;
    end
  end

  assign on_s  = (state_r == ST_VISIBLE) || (state_r == ST_HIDING);
  assign win_s = on_s
              && ({1'b0, bus.hcount} >= {1'b0, px_r}) && ({1'b0, bus.hcount} < ({1'b0, px_r} + W11))
              && ({1'b0, bus.vcount} >= {1'b0, py_r}) && ({1'b0, bus.vcount} < ({1'b0, py_r} + H11));

  // State register with its decoded visibility flag
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_HIDDEN;
      visible_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      visible_r <= (next_state_s == ST_VISIBLE) || (next_state_s == ST_HIDING);
    end
  end

  // Frame-latched sprite position
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      px_r <= 10'd0;
      py_r <= 10'd0;
    end else if (latch_s) begin
      px_r <= clamp_x_s;
      py_r <= clamp_y_s;
    end else begin
      px_r <= px_r;
      py_r <= py_r;
    end
  end

  // Raster-order ROM address, saturating on the last word until the next frame
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
    end else if (bus.frame_start) begin
      addr_r <= '0;
    end else if (win_s && (addr_r != LAST_ADDR)) begin
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

`ifdef SPRITE_FLASH_EN
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);

  logic [FC_W-1:0] flash_cnt_r;
  logic            blank_r;

  // Flash phase counter; each entry from ARMED starts in the shown phase
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_r <= '0;
      blank_r     <= 1'b0;
    end else if ((state_r == ST_ARMED) && (next_state_s == ST_VISIBLE)) begin
      flash_cnt_r <= '0;
      blank_r     <= 1'b0;
    end else if (bus.frame_start && (state_r == ST_VISIBLE)) begin
      if (flash_cnt_r == FC_W'(FLASH_FRAMES - 1)) begin
        flash_cnt_r <= '0;
        blank_r     <= ~blank_r;
      end else begin
        flash_cnt_r <= flash_cnt_r + FC_W'(1);
        blank_r     <= blank_r;
      end
    end else begin
      flash_cnt_r <= flash_cnt_r;
      blank_r     <= blank_r;
    end
  end

  assign blank_s = blank_r;
`else
  logic unused_flash_s;

  assign unused_flash_s = ^FLASH_FRAMES;
  assign blank_s        = 1'b0;
`endif

  // Two-stage pipeline: window flag meets rom_data, then key test and output
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      win_d1_r    <= 1'b0;
      pix_out_r   <= 8'h00;
      pix_valid_r <= 1'b0;
    end else begin
      win_d1_r    <= win_s;
      pix_valid_r <= win_d1_r && (bus.rom_data != KEY) && !blank_s;
      if (win_d1_r) begin
        pix_out_r <= bus.rom_data;
      end else begin
        pix_out_r <= 8'h00;
      end
    end
  end

  assign bus.rom_addr  = addr_r;
  assign bus.pix_out   = pix_out_r;
  assign bus.pix_valid = pix_valid_r;
  assign bus.visible   = visible_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: drives window-covering raster scans and
// checks addresses, keyed pixels and show/hide sequencing.
module tb_sprite_blitter;

  localparam int SPR_W = 94;
  localparam int SPR_H = 70;
  localparam int LAST  = SPR_W * SPR_H - 1;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_pix = ~clk_pix;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_px  = 0;
  int exp_py  = 0;
  bit exp_vis = 1'b0;
  logic [8:0] sb_q[$];

  function automatic logic [7:0] rom_val(input int a);
    if (a == 1) begin
      return 8'h3C;
    end else if ((a % 5) == 0) begin
      return 8'h00;
    end else begin
      return 8'(a * 7 + 3);
    end
  endfunction

  // Sprite ROM: one-cycle registered read
  always @(posedge clk_pix) begin
    bus.rom_data <= rom_val(int'(bus.rom_addr));
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One pixel clock: drive, check comb address and visibility, score the pixel from 2 cycles ago
  task automatic step(input int h, input int v, input logic fs, input logic sh, input logic hd);
    bit         win;
    int         a;
    logic [7:0] d;
    logic [8:0] e;
    bus.hcount      = 10'(h);
    bus.vcount      = 10'(v);
    bus.frame_start = fs;
    bus.show        = sh;
    bus.hide        = hd;
    win = exp_vis && (h >= exp_px) && (h < exp_px + SPR_W) && (v >= exp_py) && (v < exp_py + SPR_H);
    a   = (v - exp_py) * SPR_W + (h - exp_px);
    d   = win ? rom_val(a) : 8'h00;
    @(negedge clk_pix);
    if (win) begin
      check_val("rom_addr", 32'(bus.rom_addr), 32'(a));
    end
    check_val("visible", 32'(bus.visible), 32'(exp_vis));
    sb_q.push_back({win && (d != 8'h00), d});
    e = sb_q.pop_front();
    check_val("pix_valid", 32'(bus.pix_valid), 32'(e[8]));
    check_val("pix_out", 32'(bus.pix_out), 32'(e[7:0]));
    @(posedge clk_pix);
    #1;
    bus.frame_start = 1'b0;
    bus.show        = 1'b0;
    bus.hide        = 1'b0;
  endtask

  task automatic scan_rows(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) begin
      for (int h = exp_px - 2; h <= exp_px + SPR_W + 1; h++) begin
        step(h, v, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic scan_frame();
    scan_rows(exp_py - 1, exp_py + SPR_H);
    check_val("addr_hold", 32'(bus.rom_addr), 32'(LAST));
  endtask

  task automatic sb_restart();
    sb_q.delete();
    sb_q.push_back(9'h000);
    sb_q.push_back(9'h000);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hcount      = 10'd0;
    bus.vcount      = 10'd0;
    bus.frame_start = 1'b0;
    bus.show        = 1'b0;
    bus.hide        = 1'b0;
    bus.pos_x       = 10'd100;
    bus.pos_y       = 10'd50;
    exp_px          = 100;
    exp_py          = 50;

    repeat (3) @(posedge clk_pix);
    #1;
    check_val("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check_val("rst_visible", 32'(bus.visible), 32'd0);
    check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge clk_pix);
    rst_n = 1'b1;
    @(posedge clk_pix);
    #1;
    sb_restart();

    // show with frame_start in the same cycle only arms
    step(0, 0, 1'b1, 1'b1, 1'b0);
    scan_rows(50, 51);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    exp_vis = 1'b1;
    scan_frame();

    // reset in the middle of a drawn row
    step(0, 0, 1'b1, 1'b0, 1'b0);
    scan_rows(50, 51);
    for (int h = 100; h <= 110; h++) begin
      step(h, 52, 1'b0, 1'b0, 1'b0);
    end
    check_val("pre_rst_valid", 32'(bus.pix_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check_val("mid_rst_visible", 32'(bus.visible), 32'd0);
    check_val("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge clk_pix);
    rst_n = 1'b1;
    @(posedge clk_pix);
    #1;
    sb_restart();
    exp_vis = 1'b0;
    step(0, 0, 1'b1, 1'b0, 1'b0);
    scan_rows(50, 51);

    // clamped position at the bottom-right corner
    bus.pos_x = 10'd620;
    bus.pos_y = 10'd470;
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    exp_vis = 1'b1;
    exp_px  = 546;
    exp_py  = 410;
    scan_frame();

    // hide while visible: finish the frame, then disappear
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    scan_frame();
    step(0, 0, 1'b1, 1'b0, 1'b0);
    exp_vis = 1'b0;
    scan_rows(410, 411);

    // show and hide together while hidden
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    scan_rows(410, 410);

    // show during hiding cancels the hide
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    exp_vis = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    scan_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
